// File: rtl/run_sequencer.sv
// Start/stop sequencer for the single-cycle core: holds the core in reset, runs it until
// a halt, a PC match or the watchdog fires, drains it, then acknowledges the request.
module run_sequencer #(
    parameter int D            = 12,
    parameter int HALT_ADDR    = 128,
    parameter int CLR_CYCLES   = 2,
    parameter int DRAIN_CYCLES = 1,
    parameter int CW           = 16,
    parameter int MAX_CYCLES   = 16'hFFFF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic [D-1:0]  prog_ctr,
    input  logic          halt,
    output logic          core_rst,
    output logic          core_en,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cycle_cnt,
    output logic [2:0]    state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int TMAX = (CLR_CYCLES > DRAIN_CYCLES) ? CLR_CYCLES : DRAIN_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [D-1:0]  HALT_PC    = D'(HALT_ADDR);
    localparam logic [CW-1:0] WD_LAST    = CW'(MAX_CYCLES - 1);
    localparam logic [TW-1:0] CLR_INIT   = TW'(CLR_CYCLES - 1);
    localparam logic [TW-1:0] DRAIN_INIT = TW'(DRAIN_CYCLES - 1);

    state_t        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          to_q, to_d;
    logic          core_rst_q, core_rst_d;
    logic          core_en_q, core_en_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Four-phase handshake: req rises (sampled in IDLE) to start a run; done rises when the
    // run is over and stays high until req is sampled low, after which done drops and the
    // sequencer returns to IDLE. req is ignored at every other point.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_CLEAR;
                    tmr_d   = CLR_INIT;
                    cnt_d   = '0;
                    to_d    = 1'b0;
                end
            end
            S_CLEAR: begin
                if (tmr_q == '0) state_d = S_RUN;
                else             tmr_d   = tmr_q - 1'b1;
            end
            S_RUN: begin
                if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                tmr_d = DRAIN_INIT;
                // Halt outranks the watchdog when both land in the same cycle.
                if (halt || (prog_ctr == HALT_PC)) begin
                    state_d = S_DRAIN;
                end else if (cnt_q == WD_LAST) begin
                    state_d = S_DRAIN;
                    to_d    = 1'b1;
                end
            end
            S_DRAIN: begin
                if (tmr_q == '0) state_d = S_DONE;
                else             tmr_d   = tmr_q - 1'b1;
            end
            S_DONE: begin
                if (!req) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        core_rst_d = (state_d == S_IDLE) || (state_d == S_CLEAR);
        core_en_d  = (state_d == S_RUN);
        busy_d     = (state_d == S_CLEAR) || (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            tmr_q      <= '0;
            cnt_q      <= '0;
            to_q       <= 1'b0;
            core_rst_q <= 1'b1;
            core_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            cnt_q      <= cnt_d;
            to_q       <= to_d;
            core_rst_q <= core_rst_d;
            core_en_q  <= core_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign core_rst  = core_rst_q;
    assign core_en   = core_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign timeout   = to_q;
    assign cycle_cnt = cnt_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: two instances (default watchdog and a 50-cycle watchdog) share
// req/reset and are checked every cycle against a phase/counter model of the sequencer.
module tb_run_sequencer;

    localparam int PH_IDLE  = 0;
    localparam int PH_CLEAR = 1;
    localparam int PH_RUN   = 2;
    localparam int PH_DRAIN = 3;
    localparam int PH_DONE  = 4;
    localparam int NO_HALT  = 4095;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic [11:0] pc_a = '0, pc_b = '0;
    logic        halt_a = 1'b0, halt_b = 1'b0;

    logic        core_rst_a, core_en_a, busy_a, done_a, timeout_a;
    logic        core_rst_b, core_en_b, busy_b, done_b, timeout_b;
    logic [15:0] cycle_cnt_a, cycle_cnt_b;
    logic [2:0]  state_dbg_a, state_dbg_b;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    run_sequencer u_a (
        .clk(clk), .reset(reset), .req(req), .prog_ctr(pc_a), .halt(halt_a),
        .core_rst(core_rst_a), .core_en(core_en_a), .busy(busy_a), .done(done_a),
        .timeout(timeout_a), .cycle_cnt(cycle_cnt_a), .state_dbg(state_dbg_a)
    );

    run_sequencer #(.MAX_CYCLES(50)) u_b (
        .clk(clk), .reset(reset), .req(req), .prog_ctr(pc_b), .halt(halt_b),
        .core_rst(core_rst_b), .core_en(core_en_b), .busy(busy_b), .done(done_b),
        .timeout(timeout_b), .cycle_cnt(cycle_cnt_b), .state_dbg(state_dbg_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (phase + counters, plus the core's PC) -------------
    int   m_phase[2]   = '{PH_IDLE, PH_IDLE};
    int   m_left[2]    = '{0, 0};
    int   m_cnt[2]     = '{0, 0};
    logic m_to[2]      = '{1'b0, 1'b0};
    int   m_pc_next[2] = '{0, 0};
    int   m_max[2]     = '{65535, 50};

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                m_phase[i] = PH_IDLE; m_left[i] = 0; m_cnt[i] = 0;
                m_to[i] = 1'b0; m_pc_next[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                int   pc;
                logic h;
                pc = (i == 0) ? int'(pc_a) : int'(pc_b);
                h  = (i == 0) ? halt_a : halt_b;
                if (m_phase[i] == PH_RUN)                                  m_pc_next[i] = (pc + 1) % 4096;
                else if (m_phase[i] == PH_IDLE || m_phase[i] == PH_CLEAR)  m_pc_next[i] = 0;
                else                                                       m_pc_next[i] = pc;
                case (m_phase[i])
                    PH_IDLE: if (req) begin
                        m_phase[i] = PH_CLEAR; m_left[i] = 2; m_cnt[i] = 0; m_to[i] = 1'b0;
                    end
                    PH_CLEAR: begin
                        m_left[i]--;
                        if (m_left[i] == 0) m_phase[i] = PH_RUN;
                    end
                    PH_RUN: begin
                        if (m_cnt[i] < 65535) m_cnt[i]++;
                        if (h || pc == 128) begin
                            m_phase[i] = PH_DRAIN; m_left[i] = 1;
                        end else if (m_cnt[i] == m_max[i]) begin
                            m_phase[i] = PH_DRAIN; m_left[i] = 1; m_to[i] = 1'b1;
                        end
                    end
                    PH_DRAIN: begin
                        m_left[i]--;
                        if (m_left[i] == 0) m_phase[i] = PH_DONE;
                    end
                    default: if (!req) m_phase[i] = PH_IDLE;
                endcase
            end
        end
    end

    // ---------------- core-side drivers ----------------
    int halt_pc  = NO_HALT;
    bit noise_on = 1'b0;

    always @(negedge clk) begin
        pc_a   = 12'(m_pc_next[0]);
        pc_b   = 12'(m_pc_next[1]);
        halt_a = (int'(pc_a) == halt_pc) || (noise_on && ($urandom_range(0, 47) == 0));
        halt_b = (int'(pc_b) == halt_pc) || (noise_on && ($urandom_range(0, 47) == 0));
    end

    // ---------------- per-cycle checker and run monitors ----------------
    int clr_seen = 0, run_seen_a = 0, run_seen_b = 0, done_seen_a = 0;

    always @(negedge clk) begin
        if (busy_a && core_rst_a) clr_seen++;
        if (core_en_a) run_seen_a++;
        if (core_en_b) run_seen_b++;
        if (done_a) done_seen_a++;
        check("a.core_rst",  core_rst_a,  (m_phase[0] == PH_IDLE || m_phase[0] == PH_CLEAR));
        check("a.core_en",   core_en_a,   (m_phase[0] == PH_RUN));
        check("a.busy",      busy_a,      (m_phase[0] inside {PH_CLEAR, PH_RUN, PH_DRAIN}));
        check("a.done",      done_a,      (m_phase[0] == PH_DONE));
        check("a.timeout",   timeout_a,   m_to[0]);
        check("a.cycle_cnt", cycle_cnt_a, m_cnt[0]);
        check("b.core_rst",  core_rst_b,  (m_phase[1] == PH_IDLE || m_phase[1] == PH_CLEAR));
        check("b.core_en",   core_en_b,   (m_phase[1] == PH_RUN));
        check("b.busy",      busy_b,      (m_phase[1] inside {PH_CLEAR, PH_RUN, PH_DRAIN}));
        check("b.done",      done_b,      (m_phase[1] == PH_DONE));
        check("b.timeout",   timeout_b,   m_to[1]);
        check("b.cycle_cnt", cycle_cnt_b, m_cnt[1]);
    end

    // ---------------- driver tasks ----------------
    task automatic start_run();
        @(negedge clk);
        req = 1'b1;
        clr_seen = 0; run_seen_a = 0; run_seen_b = 0; done_seen_a = 0;
    endtask

    task automatic wait_both_done(input int budget);
        int n;
        n = 0;
        while (!(done_a && done_b) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_done_in_budget", (done_a && done_b), 1);
    endtask

    task automatic wait_both_idle(input int budget);
        int n;
        n = 0;
        while ((busy_a || done_a || busy_b || done_b) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_in_budget", (busy_a || done_a || busy_b || done_b), 0);
    endtask

    typedef struct {
        int   halt_pc;
        int   cnt_a;
        logic to_a;
        int   cnt_b;
        logic to_b;
    } vec_t;

    vec_t        vecs[7];
    logic [15:0] exp_q[$];

    initial begin
        logic [15:0] exp_cnt;

        vecs[0] = '{NO_HALT, 129, 1'b0, 50, 1'b1};  // natural PC end vs watchdog
        vecs[1] = '{37,       38, 1'b0, 38, 1'b0};  // explicit halt
        vecs[2] = '{49,       50, 1'b0, 50, 1'b0};  // halt on the watchdog cycle
        vecs[3] = '{48,       49, 1'b0, 49, 1'b0};
        vecs[4] = '{0,         1, 1'b0,  1, 1'b0};  // halt on first RUN cycle
        vecs[5] = '{127,     128, 1'b0, 50, 1'b1};
        vecs[6] = '{50,       51, 1'b0, 50, 1'b1};  // halt one cycle too late for b

        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.core_rst", core_rst_a, 1);
        check("rst.core_en",  core_en_a,  0);
        check("rst.busy",     busy_a,     0);
        check("rst.cycle_cnt", cycle_cnt_a, 0);
        reset = 1'b1;
        @(negedge clk);

        // Table-driven complete runs.
        for (int v = 0; v < 7; v++) begin
            halt_pc = vecs[v].halt_pc;
            exp_q.push_back(16'(vecs[v].cnt_a));
            start_run();
            wait_both_done(400);
            exp_cnt = exp_q.pop_front();
            check("vec.cnt_a",  cycle_cnt_a, exp_cnt);
            check("vec.to_a",   timeout_a,   vecs[v].to_a);
            check("vec.cnt_b",  cycle_cnt_b, vecs[v].cnt_b);
            check("vec.to_b",   timeout_b,   vecs[v].to_b);
            check("vec.clear_cycles", clr_seen, 2);
            check("vec.run_cycles_a", run_seen_a, vecs[v].cnt_a);
            check("vec.run_cycles_b", run_seen_b, vecs[v].cnt_b);
            req = 1'b0;
            @(negedge clk);
            check("vec.done_drop_a", done_a, 0);
            check("vec.done_drop_b", done_b, 0);
            check("vec.idle_keeps_cnt", cycle_cnt_a, exp_cnt);
        end

        // req pulsed for a single cycle: full run, done for exactly one cycle.
        halt_pc = 20;
        start_run();
        @(negedge clk);
        req = 1'b0;
        wait_both_done(400);
        repeat (4) @(negedge clk);
        check("pulse.cnt_a", cycle_cnt_a, 21);
        check("pulse.done_cycles", done_seen_a, 1);
        check("pulse.idle", busy_a || done_a, 0);

        // req held through DONE: no restart until it drops and rises again.
        halt_pc = 10;
        start_run();
        wait_both_done(400);
        repeat (10) @(negedge clk);
        check("hold.done",  done_a, 1);
        check("hold.busy",  busy_a, 0);
        check("hold.no_restart", run_seen_a, 11);
        req = 1'b0;
        repeat (2) @(negedge clk);
        start_run();
        @(negedge clk);
        check("rerun.clear", core_rst_a && busy_a, 1);
        check("rerun.cnt_cleared", cycle_cnt_a, 0);
        wait_both_done(400);
        check("rerun.cnt_a", cycle_cnt_a, 11);
        req = 1'b0;
        @(negedge clk);

        // Asynchronous reset in the middle of RUN.
        halt_pc = NO_HALT;
        start_run();
        begin
            int n;
            n = 0;
            while (cycle_cnt_a != 16'd20 && n < 300) begin
                @(negedge clk);
                n++;
            end
            check("midrst.reach_20", cycle_cnt_a, 20);
        end
        #2 reset = 1'b0;
        #1;
        check("midrst.core_rst", core_rst_a, 1);
        check("midrst.core_en",  core_en_a,  0);
        check("midrst.busy",     busy_a,     0);
        check("midrst.cnt",      cycle_cnt_a, 0);
        check("midrst.b_busy",   busy_b,     0);
        req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("midrst.idle_busy", busy_a, 0);
        check("midrst.idle_rst",  core_rst_a, 1);
        check("midrst.idle_done", done_a, 0);

        // Randomized runs with random req hold times and stray halts.
        for (int r = 0; r < 30; r++) begin
            int hold;
            halt_pc  = $urandom_range(0, 140);
            noise_on = ($urandom_range(0, 1) == 1);
            hold     = $urandom_range(1, 200);
            start_run();
            repeat (hold) @(negedge clk);
            req = 1'b0;
            wait_both_idle(400);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        noise_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
- Start/stop controller for the single-cycle core (PC, instruction ROM, control, ALU, register file, data memory).
- Accepts a four-phase req/done handshake from the bench or host, and holds the core in reset for a fixed number of cycles.
- Enables the core, watches the program counter or an explicit halt for completion, and enforces a cycle-limit watchdog.
- Drains the core, then reports done, timeout and the executed cycle count.

Parameters:
D, 12, program counter width (matches PC).
HALT_ADDR, 128, PC value that signals program end.
CLR_CYCLES, 2, cycles core_rst is held high in CLEAR (>=1).
DRAIN_CYCLES, 1, cycles with core_en low after completion before done (>=1).
CW, 16, cycle counter width.
MAX_CYCLES, 16'hFFFF, watchdog limit in RUN cycles (1..2^CW-1).

Ports:
clk  input  1  clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-low reset.
req  input  1  start request, level, four-phase handshake.
prog_ctr  input  D  current core PC.
halt  input  1  explicit halt from control decoder, active-high.
core_rst  output  1  synchronous reset to PC/core, active-high.
core_en  output  1  core advance enable (PC update, reg/mem writes gated by it).
busy  output  1  high in CLEAR, RUN, DRAIN.
done  output  1  run complete; handshake acknowledge.
timeout  output  1  last run ended by watchdog; valid while done=1, held until next CLEAR.
cycle_cnt  output  CW  RUN cycles executed by the last or current run.

Behaviour:
- Reset (reset=0, asynchronous, any state): state=IDLE, core_rst=1, core_en=0, busy=0, done=0, timeout=0, cycle_cnt=0. Applies immediately, including mid-run. Leaving reset takes effect on the first clk edge with reset=1.
- All outputs are registered, decoded from state and registers only. No combinational path from any input to any output.
- IDLE:
  - core_rst=1, core_en=0.
  - req=1 sampled -> CLEAR. Clear cycle_cnt, clear timeout, load clear counter with CLR_CYCLES-1.
- CLEAR:
  - core_rst=1, core_en=0, busy=1.
  - Clear counter decrements each cycle; at 0 -> RUN.
  - Exactly CLR_CYCLES cycles in CLEAR.
- RUN:
  - core_rst=0, core_en=1, busy=1.
  - Every RUN cycle, cycle_cnt increments; it saturates at 2^CW-1 and never wraps.
  - Completion check uses the current-cycle values, and the cycle is counted.
  - If halt=1 or prog_ctr==HALT_ADDR -> DRAIN, timeout stays 0.
  - Else if cycle_cnt==MAX_CYCLES-1 (this is the MAX_CYCLES-th RUN cycle) -> DRAIN, timeout<=1.
  - Halt and watchdog in the same cycle: halt wins, timeout=0.
  - The core's own writes in the completing cycle are allowed (core_en is still 1 that cycle).
- DRAIN:
  - core_rst=0, core_en=0, busy=1.
  - Lasts DRAIN_CYCLES cycles, then -> DONE.
  - PC is frozen, so the completion condition is not re-evaluated.
- DONE:
  - done=1, busy=0, core_en=0, core_rst=0. Core state stays visible for readout.
  - Hold until req=0 sampled -> IDLE, done<=0.
  - If req was already low, DONE lasts exactly one cycle.
- req changes in CLEAR/RUN/DRAIN are ignored; the run always completes.
- A new run requires a return to IDLE. req held high through DONE does not restart; it must drop and rise again.
- cycle_cnt and timeout keep their values in IDLE until the next CLEAR.
- Illegal or unused state encodings -> IDLE on the next edge, with IDLE outputs.

Test Plan:
1. Basic run, halt at PC:
   - Stimulus: reset low 3 cycles, then high; req=1 at cycle 5; prog_ctr model counts 0.. when core_en=1 and reset when core_rst=1.
   - Required: core_rst high 2 cycles; RUN cycles = 129 (PC 0..128), so cycle_cnt=129; core_en falls; done=1 after 1 drain cycle; timeout=0; drop req -> done=0 the next cycle.
2. Explicit halt:
   - Stimulus: halt=1 when PC=37.
   - Required: cycle_cnt=38, timeout=0, done asserted DRAIN_CYCLES+1 edges after the halt cycle.
3. Watchdog:
   - Stimulus: MAX_CYCLES=50, PC never reaches 128 and halt never asserts.
   - Required: exactly 50 RUN cycles, cycle_cnt=50, timeout=1 with done=1.
4. Tie:
   - Stimulus: MAX_CYCLES=50, halt=1 on the 50th RUN cycle.
   - Required: timeout=0, cycle_cnt=50.
5. Handshake abuse:
   - Stimulus A: req pulsed 1 cycle. Required: full run occurs and done is high for exactly 1 cycle.
   - Stimulus B: req held high after done. Required: no restart; drop then raise req -> second run, cycle_cnt cleared in CLEAR and counting from 0.
6. Reset mid-run:
   - Stimulus: assert reset asynchronously (between edges) at RUN cycle 20.
   - Required: core_rst=1, core_en=0, busy=0, cycle_cnt=0 immediately, without waiting for a clk edge. After release, state is IDLE and waits for req.
